// File: rtl/cvp14_memory.sv
// cvp14_memory: word-addressed main memory answering the CVP14 core bus.
// Clears itself after reset and shares its array with a program loader.
module cvp14_memory #(
  parameter int ADDR_BITS      = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        V,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        busy,
  output logic        err,
  output logic        v_sticky,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]           state;
  logic [ADDR_BITS-1:0] clr_idx;
  logic [15:0]          mem [DEPTH];

  logic                 ready;
  logic                 core_hit;
  logic                 ld_hit;
  logic                 ld_fire;
  logic                 rd_only;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [15:0]          wdata;

  assign ready    = (state == ST_READY);
  assign busy     = (state == ST_CLEAR);
  assign core_hit = ((Addr >> ADDR_BITS) == 16'd0);
  assign ld_hit   = ((ld_addr >> ADDR_BITS) == 16'd0);
  assign rd_only  = RD & ~WR;
  assign ld_ready = ready & ~RD & ~WR & ~Reset;
  assign ld_fire  = ld_valid & ld_ready;

  // Single write port: clear, core and loader never overlap.
  always_comb begin
    we    = 1'b0;
    waddr = clr_idx;
    wdata = 16'd0;
    if (!Reset) begin
      if (!ready) begin
        we = 1'b1;
      end else if (WR) begin
        we    = core_hit;
        waddr = Addr[ADDR_BITS-1:0];
        wdata = WrData;
      end else if (ld_fire) begin
        we    = ld_hit;
        waddr = ld_addr[ADDR_BITS-1:0];
        wdata = ld_data;
      end
    end
  end

  always_ff @(posedge Clk1) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx  <= '0;
      RdData   <= 16'd0;
      err      <= 1'b0;
      v_sticky <= 1'b0;
      wr_count <= 16'd0;
    end else begin
      v_sticky <= v_sticky | V;
      if (!ready) begin
        clr_idx <= clr_idx + ADDR_BITS'(1);
        if (clr_idx == '1) state <= ST_READY;
        if (RD | WR) err <= 1'b1;
      end else begin
        unique case (1'b1)
          rd_only: begin
            RdData <= core_hit ? mem[Addr[ADDR_BITS-1:0]] : 16'd0;
            if (!core_hit) err <= 1'b1;
          end
          WR: begin
            if (core_hit) wr_count <= wr_count + 16'd1;
            if (!core_hit || RD) err <= 1'b1;
          end
          ld_fire: begin
            if (!ld_hit) err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cvp14_memory.sv
// tb_cvp14_memory: directed vectors for cvp14_memory with ADDR_BITS=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cvp14_memory;

  logic        Clk1;
  logic        Reset;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        busy;
  logic        err;
  logic        v_sticky;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;
  int n;

  cvp14_memory #(
    .ADDR_BITS(4),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .Clk1(Clk1),
    .Reset(Reset),
    .Addr(Addr),
    .RD(RD),
    .WR(WR),
    .V(V),
    .WrData(WrData),
    .RdData(RdData),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .busy(busy),
    .err(err),
    .v_sticky(v_sticky),
    .wr_count(wr_count)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic rd(input logic [15:0] a);
    RD   = 1'b1;
    Addr = a;
    tick();
    RD   = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Addr = 0; RD = 0; WR = 0; V = 0;
    WrData = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    tick();
    Reset = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd1);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_vst", {15'd0, v_sticky}, 16'd0);
    chk("rst_wrc", wr_count, 16'd0);
    chk("rst_rdd", RdData, 16'd0);
    chk("rst_ldr", {15'd0, ld_ready}, 16'd0);

    // clear with one V pulse
    n = 0;
    while (busy && n < 100) begin
      V = (n == 2);
      tick();
      n++;
    end
    V = 1'b0;
    chk("clr_len", 16'(n), 16'd16);
    chk("clr_vst", {15'd0, v_sticky}, 16'd1);
    chk("clr_err", {15'd0, err}, 16'd0);
    tick();
    chk("vst_hold", {15'd0, v_sticky}, 16'd1);

    // loader back-to-back
    ld_valid = 1; ld_addr = 3; ld_data = 16'h1234;
    #1 chk("ld_rdy0", {15'd0, ld_ready}, 16'd1);
    tick();
    ld_addr = 4; ld_data = 16'hABCD;
    #1 chk("ld_rdy1", {15'd0, ld_ready}, 16'd1);
    tick();
    ld_valid = 0;
    RD = 1; Addr = 3;
    tick();
    chk("rd3", RdData, 16'h1234);
    Addr = 4;
    tick();
    chk("rd4", RdData, 16'hABCD);
    RD = 0;
    tick();
    chk("rd_hold", RdData, 16'hABCD);
    chk("ld_wrc", wr_count, 16'd0);

    // core write then read-after-write
    WR = 1; Addr = 5; WrData = 16'h00FF;
    tick();
    WR = 0;
    rd(16'd5);
    chk("raw5", RdData, 16'h00FF);
    chk("wrc1", wr_count, 16'd1);
    chk("err_ok", {15'd0, err}, 16'd0);

    // core priority over loader
    ld_valid = 1; ld_addr = 7; ld_data = 16'h1111;
    RD = 1; Addr = 3;
    #1 chk("ld_blk", {15'd0, ld_ready}, 16'd0);
    tick();
    RD = 0;
    chk("pri_rd3", RdData, 16'h1234);
    ld_addr = 6; ld_data = 16'h5A5A;
    #1 chk("ld_idle", {15'd0, ld_ready}, 16'd1);
    tick();
    ld_valid = 0;
    rd(16'd6);
    chk("ld6", RdData, 16'h5A5A);
    rd(16'd7);
    chk("no_ld7", RdData, 16'h0000);

    // out of range
    rd(16'h0010);
    chk("oor_rdd", RdData, 16'h0000);
    chk("oor_err", {15'd0, err}, 16'd1);
    WR = 1; Addr = 16'h0010; WrData = 16'hBEEF;
    tick();
    WR = 0;
    chk("oor_wrc", wr_count, 16'd1);
    rd(16'd0);
    chk("oor_alias", RdData, 16'h0000);

    // reset mid-clear at clr_idx=7
    Reset = 1; tick(); Reset = 0;
    V = 1; tick(); V = 0;
    for (int i = 0; i < 6; i++) tick();
    Reset = 1; tick(); Reset = 0;
    chk("rr_vst", {15'd0, v_sticky}, 16'd0);
    chk("rr_err", {15'd0, err}, 16'd0);
    chk("rr_wrc", wr_count, 16'd0);
    wait_clear(n);
    chk("rr_len", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) begin
      rd(16'(i));
      chk($sformatf("zero%0d", i), RdData, 16'h0000);
    end
    chk("zero_err", {15'd0, err}, 16'd0);

    // RD and WR together
    WR = 1; Addr = 9; WrData = 16'h4242;
    tick();
    WR = 0;
    rd(16'd9);
    chk("rd9", RdData, 16'h4242);
    RD = 1; WR = 1; Addr = 2; WrData = 16'h7777;
    tick();
    RD = 0; WR = 0;
    chk("rw_hold", RdData, 16'h4242);
    chk("rw_err", {15'd0, err}, 16'd1);
    chk("rw_wrc", wr_count, 16'd2);
    rd(16'd2);
    chk("rw_wr2", RdData, 16'h7777);

    // request during clear
    Reset = 1; tick(); Reset = 0;
    chk("cr_err0", {15'd0, err}, 16'd0);
    RD = 1; Addr = 2;
    tick();
    RD = 0;
    chk("cr_err", {15'd0, err}, 16'd1);
    chk("cr_rdd", RdData, 16'h0000);
    wait_clear(n);
    chk("cr_len", 16'(n), 16'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvp14_memory.md
# cvp14_memory

Word-addressed main memory that answers the CVP14 core's memory bus (Addr/RD/WR/V), acting as the responder side of the protocol the core initiates. It serves single-word reads with one-cycle latency, which matches the core sampling DataIn in the state after RD, and performs same-cycle writes. It also clears itself after reset and accepts a program-loader port that shares the array with the core. It sits between the core and the testbench or loader.

## Interface

Parameters:
- ADDR_BITS, 10, implemented depth is 2^ADDR_BITS 16-bit words.
- CLEAR_ON_RESET, 1, when 1, zero every word after reset before serving traffic.

Ports:
- Clk1  in  1  sole clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- Addr  in  16  word address from the core.
- RD  in  1  read request, one cycle wide.
- WR  in  1  write request, one cycle wide.
- V  in  1  core over/underflow flag, sampled every cycle.
- WrData  in  16  write data (core dataOut).
- RdData  out  16  read data to the core (core DataIn); registered.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle.
- ld_addr  in  16  loader word address.
- ld_data  in  16  loader write data.
- busy  out  1  high while clearing.
- err  out  1  sticky protocol/range error.
- v_sticky  out  1  sticky OR of V.
- wr_count  out  16  number of core writes committed; wraps at 16'hFFFF to 0.

## Operation

- FSM states:
  - CLEAR: write 0 to word clr_idx, increment clr_idx; after word 2^ADDR_BITS-1 go to READY.
  - READY: serve core and loader traffic.
- Reset: next state is CLEAR if CLEAR_ON_RESET=1, else READY. Output reset values:
  - clr_idx=0, RdData=0, err=0, v_sticky=0, wr_count=0, ld_ready=0.
  - busy=CLEAR_ON_RESET.
- Reset mid-CLEAR or mid-traffic restarts the FSM from clr_idx=0. Array contents are not otherwise guaranteed.
- In-range means Addr[15:ADDR_BITS]==0. Only Addr[ADDR_BITS-1:0] indexes the array.
- READY, RD=1, WR=0:
  - In range: RdData <= mem[Addr].
  - Out of range: RdData <= 0 and err <= 1.
- READY, WR=1, RD=0:
  - In range: mem[Addr] <= WrData and wr_count increments.
  - Out of range: write dropped and err <= 1.
- RD=1 and WR=1 together: the write is performed per the rules above, RdData holds, err <= 1.
- RdData holds its value in every cycle without a read.
- Loader:
  - ld_ready = (state==READY) & ~RD & ~WR (combinational).
  - ld_valid & ld_ready writes mem[ld_addr] <= ld_data using the same range rule. Out of range sets err.
  - Loader writes do not change wr_count.
- CLEAR with RD or WR asserted: the request is ignored, RdData holds, err <= 1.
- v_sticky <= v_sticky | V every cycle, including during CLEAR. It is cleared only by Reset.
- err is cleared only by Reset.

## Timing

- Read latency is 1 cycle. With RD at edge t, RdData is valid after edge t+1 and stable until the next accepted read.
- Write is committed at the edge where WR is sampled.
- Read-after-write to the same address in consecutive cycles returns the new data.
- CLEAR lasts exactly 2^ADDR_BITS cycles after the cycle Reset deasserts. busy falls on the same edge the FSM enters READY.
- A loader handshake completes in one cycle. When ld_valid is held, transfers run back-to-back at one per cycle while the core is idle.
- Core accesses have priority over the loader; there is no arbitration delay for the core.

## Test plan

- Reset with CLEAR_ON_RESET=1, ADDR_BITS=4 -> busy=1 for exactly 16 cycles, then 0. A read of every address returns 16'h0000. err=0.
- Loader writes 16'h1234 at 3 and 16'hABCD at 4 with ld_valid held -> 2 handshakes in 2 cycles. RD@3 then RD@4 gives RdData 16'h1234, then 16'hABCD, each one cycle after its RD.
- Core WR Addr=5 WrData=16'h00FF, then RD Addr=5 next cycle -> RdData=16'h00FF one cycle later. wr_count=1.
- RD Addr=16'h0400 with ADDR_BITS=10 -> RdData=0, err=1. A WR to the same address leaves wr_count unchanged.
- ld_valid held while the core issues RD -> ld_ready=0 that cycle and the loader write occurs the next idle cycle. RD&WR together -> err=1.
- V pulses once during CLEAR -> v_sticky=1 and stays high. Reset mid-CLEAR at clr_idx=7 -> busy stays high a full 16 cycles after release, and v_sticky=0.
